// File: rtl/ldm_stm_pkg.sv
// ldm_stm_pkg: shared types and helpers for the LDM/STM memory sequencer.
//   state_e    - sequencer FSM states
//   mode_e     - addressing mode encoded as {P, U}
//   WORD_BYTES - byte stride between consecutive word accesses
//   popcount16 - number of registers selected by a 16-bit register list
package ldm_stm_pkg;

    localparam int unsigned WORD_BYTES = 4;
    // Wide enough to hold a register count of 0..16.
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned REG_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Encoded as {P, U}.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } mode_e;

    function automatic logic [CNT_W-1:0] popcount16(input logic [15:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/ldm_stm_rd_pipe.sv
// ldm_stm_rd_pipe: DEPTH-stage valid/index shift pipe. Delays each read
// strobe and its destination register so the register-file write lines up
// with the cycle the memory returns data.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   valid_i/idx_i - read issued this cycle and its destination register
//   valid_o/idx_o - the same, DEPTH cycles later (idx_o is 0 when invalid)
module ldm_stm_rd_pipe
    import ldm_stm_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [REG_W-1:0] idx_i,
    output logic             valid_o,
    output logic [REG_W-1:0] idx_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][REG_W-1:0] idx_q;

    // Shift register; the index is zeroed on empty slots to keep idx_o quiet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
            vld_q[0] <= valid_i;
            idx_q[0] <= valid_i ? idx_i : '0;
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/ldm_stm_mem_sequencer.sv
// ldm_stm_mem_sequencer: consumer of the LDM/STM register-address stream.
// Each accepted (reg_addr, en) beat becomes one word memory access plus the
// matching register-file read (STM) or delayed register-file write (LDM).
// The block also computes the IA/IB/DA/DB start address, performs optional
// base writeback and pulses done_out at the end.
//   clk_in, reset_in         - clock, asynchronous active-low reset
//   ldm_stm_start_in         - start pulse; fields below sampled with it
//   reg_list_in, base_addr_in, rn_in, p_in, u_in, l_in, w_in
//   reg_addr_in, ldm_stm_en_in - beat stream from the address generator
//   rf_rd_data_in            - combinational register-file read data
//   mem_rdata_in             - memory read data, MEM_RD_LAT after the strobe
//   mem_*_out                - word memory access (address/strobes/store data)
//   rf_rd_addr_out           - register read index for stores
//   rf_wr_*_out              - register-file write port (loads and writeback)
//   busy_out, done_out       - transfer in progress / one-cycle completion
module ldm_stm_mem_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              ldm_stm_start_in,
    input  logic [15:0]       reg_list_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [3:0]        rn_in,
    input  logic              p_in,
    input  logic              u_in,
    input  logic              l_in,
    input  logic              w_in,
    input  logic [3:0]        reg_addr_in,
    input  logic              ldm_stm_en_in,
    input  logic [DATA_W-1:0] rf_rd_data_in,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_rd_en_out,
    output logic              mem_wr_en_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    output logic [3:0]        rf_rd_addr_out,
    output logic              rf_wr_en_out,
    output logic [3:0]        rf_wr_addr_out,
    output logic [DATA_W-1:0] rf_wr_data_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  wb_data_q, wb_data_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic [REG_W-1:0]   rn_q, rn_d;
    logic [REG_W-1:0]   rf_rd_addr_q, rf_rd_addr_d;
    logic               l_q, l_d;
    logic               w_q, w_d;
    logic               wb_skip_q, wb_skip_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wb_q, wb_d;

    logic               beat;
    logic [CNT_W-1:0]   n_regs;
    logic [ADDR_W-1:0]  span;
    logic [ADDR_W-1:0]  start_addr;
    logic               pipe_vld;
    logic [REG_W-1:0]   pipe_idx;

    // Transfer size and lowest address, evaluated from the start-time fields.
    assign n_regs = popcount16(reg_list_in);
    assign span   = ADDR_W'(n_regs) * STRIDE;

    always_comb begin
        start_addr = base_addr_in;
        case (mode_e'({p_in, u_in}))
            MODE_IA: start_addr = base_addr_in;
            MODE_IB: start_addr = base_addr_in + STRIDE;
            MODE_DA: start_addr = base_addr_in - span + STRIDE;
            MODE_DB: start_addr = base_addr_in - span;
            default: start_addr = base_addr_in;
        endcase
    end

    // Beats outside XFER or past the latched count are dropped.
    assign beat = (state_q == ST_XFER) && ldm_stm_en_in && (remaining_q != '0);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mem_addr_d   = mem_addr_q;
        wb_data_d    = wb_data_q;
        remaining_d  = remaining_q;
        rn_d         = rn_q;
        rf_rd_addr_d = rf_rd_addr_q;
        l_d          = l_q;
        w_d          = w_q;
        wb_skip_d    = wb_skip_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        // Loads issued but not yet written back to the register file.
        pend_d       = pend_q + CNT_W'(beat & l_q) - CNT_W'(pipe_vld);

        case (state_q)
            ST_IDLE: begin
                if (ldm_stm_start_in) begin
                    addr_d      = start_addr;
                    remaining_d = n_regs;
                    rn_d        = rn_in;
                    l_d         = l_in;
                    w_d         = w_in;
                    // A load that includes Rn keeps the loaded value.
                    wb_skip_d   = l_in & w_in & reg_list_in[rn_in];
                    wb_data_d   = u_in ? (base_addr_in + span) : (base_addr_in - span);
                    pend_d      = '0;
                    state_d     = (n_regs == '0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    mem_addr_d   = addr_q;
                    addr_d       = addr_q + STRIDE;
                    remaining_d  = remaining_q - CNT_W'(1);
                    rf_rd_addr_d = reg_addr_in;
                    mem_rd_d     = l_q;
                    mem_wr_d     = ~l_q;
                    if (remaining_q == CNT_W'(1)) begin
                        if (l_q) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = w_q ? ST_WB : ST_DONE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Leave in the cycle the final load's register write issues.
                if (pipe_vld && (pend_q == CNT_W'(1))) begin
                    state_d = (w_q && !wb_skip_q) ? ST_WB : ST_DONE;
                end
            end
            ST_WB: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        wb_d   = (state_d == ST_WB);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            wb_data_q    <= '0;
            remaining_q  <= '0;
            pend_q       <= '0;
            rn_q         <= '0;
            rf_rd_addr_q <= '0;
            l_q          <= 1'b0;
            w_q          <= 1'b0;
            wb_skip_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wb_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mem_addr_q   <= mem_addr_d;
            wb_data_q    <= wb_data_d;
            remaining_q  <= remaining_d;
            pend_q       <= pend_d;
            rn_q         <= rn_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            l_q          <= l_d;
            w_q          <= w_d;
            wb_skip_q    <= wb_skip_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wb_q         <= wb_d;
        end
    end

    // Read strobe and its register index, delayed to the data-return cycle.
    ldm_stm_rd_pipe #(
        .DEPTH (MEM_RD_LAT)
    ) u_rd_pipe (
        .clk_i   (clk_in),
        .rst_ni  (reset_in),
        .valid_i (mem_rd_q),
        .idx_i   (rf_rd_addr_q),
        .valid_o (pipe_vld),
        .idx_o   (pipe_idx)
    );

    assign mem_addr_out   = mem_addr_q;
    assign mem_rd_en_out  = mem_rd_q;
    assign mem_wr_en_out  = mem_wr_q;
    // Store data passes straight from the register file during the strobe.
    assign mem_wdata_out  = mem_wr_q ? rf_rd_data_in : '0;
    assign rf_rd_addr_out = rf_rd_addr_q;

    // Load writes and the writeback cycle never overlap (WB follows the drain).
    assign rf_wr_en_out   = pipe_vld | wb_q;
    assign rf_wr_addr_out = pipe_vld ? pipe_idx : (wb_q ? rn_q : '0);
    assign rf_wr_data_out = pipe_vld ? mem_rdata_in : (wb_q ? DATA_W'(wb_data_q) : '0);

    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_ldm_stm_mem_sequencer.sv
// Testbench for ldm_stm_mem_sequencer: table of directed LDM/STM vectors,
// a reset-abort sequence and randomized transfers, all checked against a
// transaction-level model of addresses, strobes, register writes and timing.
module tb_ldm_stm_mem_sequencer;

    localparam int LAT = 1;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        ldm_stm_start_in;
    logic [15:0] reg_list_in;
    logic [31:0] base_addr_in;
    logic [3:0]  rn_in;
    logic        p_in, u_in, l_in, w_in;
    logic [3:0]  reg_addr_in;
    logic        ldm_stm_en_in;
    logic [31:0] rf_rd_data_in;
    logic [31:0] mem_rdata_in;
    logic [31:0] mem_addr_out;
    logic        mem_rd_en_out, mem_wr_en_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  rf_rd_addr_out;
    logic        rf_wr_en_out;
    logic [3:0]  rf_wr_addr_out;
    logic [31:0] rf_wr_data_out;
    logic        busy_out, done_out;

    ldm_stm_mem_sequencer #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_RD_LAT (LAT)
    ) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .ldm_stm_start_in (ldm_stm_start_in),
        .reg_list_in      (reg_list_in),
        .base_addr_in     (base_addr_in),
        .rn_in            (rn_in),
        .p_in             (p_in),
        .u_in             (u_in),
        .l_in             (l_in),
        .w_in             (w_in),
        .reg_addr_in      (reg_addr_in),
        .ldm_stm_en_in    (ldm_stm_en_in),
        .rf_rd_data_in    (rf_rd_data_in),
        .mem_rdata_in     (mem_rdata_in),
        .mem_addr_out     (mem_addr_out),
        .mem_rd_en_out    (mem_rd_en_out),
        .mem_wr_en_out    (mem_wr_en_out),
        .mem_wdata_out    (mem_wdata_out),
        .rf_rd_addr_out   (rf_rd_addr_out),
        .rf_wr_en_out     (rf_wr_en_out),
        .rf_wr_addr_out   (rf_wr_addr_out),
        .rf_wr_data_out   (rf_wr_data_out),
        .busy_out         (busy_out),
        .done_out         (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rreg;
    } mem_ev_t;

    typedef struct {
        int          cyc;
        logic [3:0]  rg;
        logic [31:0] data;
    } rf_ev_t;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
    } dl_t;

    typedef struct {
        logic        p, u, l, w;
        logic [3:0]  rn;
        logic [15:0] list;
        logic [31:0] base;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic        exp_wb;
        logic [31:0] exp_wbv;
    } vec_t;

    mem_ev_t mem_q[$];
    rf_ev_t  rf_q[$];
    int      done_q[$];
    dl_t     dl_q[$];
    int      busy_cnt;
    int      both_cnt;
    int      cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;
    vec_t    vecs[7];

    function automatic logic [31:0] rf_word(input logic [3:0] r);
        return 32'hC0DE_0000 | (32'(r) << 8) | 32'(r);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Register file read port.
    assign rf_rd_data_in = rf_word(rf_rd_addr_out);

    function automatic logic outs_or();
        return |{mem_addr_out, mem_rd_en_out, mem_wr_en_out, mem_wdata_out,
                 rf_rd_addr_out, rf_wr_en_out, rf_wr_addr_out, rf_wr_data_out,
                 busy_out, done_out};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: memory model returns data LAT cycles after a read strobe,
    // then outputs are sampled into event queues.
    task automatic step();
        dl_t d;
        @(posedge clk_in);
        #1;
        cyc++;
        if (dl_q.size() >= LAT) begin
            d = dl_q.pop_front();
            mem_rdata_in = d.v ? mem_word(d.a) : $urandom;
        end
        #1;
        if (mem_rd_en_out && mem_wr_en_out) both_cnt++;
        if (mem_rd_en_out || mem_wr_en_out)
            mem_q.push_back('{cyc, mem_rd_en_out, mem_addr_out, mem_wdata_out, rf_rd_addr_out});
        if (rf_wr_en_out) rf_q.push_back('{cyc, rf_wr_addr_out, rf_wr_data_out});
        if (done_out) done_q.push_back(cyc);
        if (busy_out) busy_cnt++;
        dl_q.push_back('{mem_rd_en_out, mem_addr_out});
    endtask

    task automatic run_xfer(input logic p, input logic u, input logic l, input logic w,
                            input logic [3:0] rn, input logic [15:0] list,
                            input logic [31:0] base, input int gap_pct);
        logic [3:0]  regs[$];
        int          bc[$];
        rf_ev_t      exp_rf[$];
        int          s, n, waited, exp_done;
        logic [31:0] four_n, lo;
        bit          wb;

        mem_q.delete(); rf_q.delete(); done_q.delete();
        busy_cnt = 0; both_cnt = 0;
        for (int r = 0; r < 16; r++) if (list[r]) regs.push_back(4'(r));
        n = regs.size();

        ldm_stm_start_in = 1'b1; reg_list_in = list; base_addr_in = base; rn_in = rn;
        p_in = p; u_in = u; l_in = l; w_in = w; ldm_stm_en_in = 1'b0;
        s = cyc;
        step();
        ldm_stm_start_in = 1'b0;
        // Fields are only meaningful with the start pulse.
        reg_list_in = 16'($urandom); base_addr_in = $urandom; rn_in = 4'($urandom);
        {p_in, u_in, l_in, w_in} = 4'($urandom);

        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                ldm_stm_en_in = 1'b0; reg_addr_in = 4'($urandom); step();
            end
            if (i == 1) begin
                ldm_stm_start_in = 1'b1; ldm_stm_en_in = 1'b0; reg_list_in = 16'hFFFF;
                step();
                ldm_stm_start_in = 1'b0;
            end
            ldm_stm_en_in = 1'b1; reg_addr_in = regs[i]; bc.push_back(cyc);
            step();
        end
        repeat (3) begin
            ldm_stm_en_in = 1'b1; reg_addr_in = 4'($urandom); step();
        end
        ldm_stm_en_in = 1'b0;
        waited = 0;
        while (done_q.size() == 0 && waited < 80) begin
            step(); waited++;
        end
        repeat (4) step();

        four_n = 32'(n) * 32'd4;
        lo = u ? (base + (p ? 32'd4 : 32'd0)) : (base - four_n + (p ? 32'd0 : 32'd4));
        wb = w && (n != 0) && !(l && list[rn]);

        chk("mem_beats", 64'(mem_q.size()), 64'(n));
        for (int i = 0; i < n && i < mem_q.size(); i++) begin
            chk("mem_addr", mem_q[i].addr, lo + 32'(4 * i));
            chk("mem_cycle", 64'(mem_q[i].cyc), 64'(bc[i] + 1));
            chk("mem_dir_rd", mem_q[i].rd, l);
            if (!l) begin
                chk("stm_rf_rd_addr", mem_q[i].rreg, regs[i]);
                chk("stm_wdata", mem_q[i].wdata, rf_word(regs[i]));
            end
        end

        if (l) for (int i = 0; i < n; i++)
            exp_rf.push_back('{bc[i] + 1 + LAT, regs[i], mem_word(lo + 32'(4 * i))});
        exp_done = (n == 0) ? s + 1
                 : ((l ? bc[n-1] + 1 + LAT : bc[n-1]) + 1 + (wb ? 1 : 0));
        if (wb) exp_rf.push_back('{exp_done - 1, rn, u ? base + four_n : base - four_n});

        chk("rf_writes", 64'(rf_q.size()), 64'(exp_rf.size()));
        for (int i = 0; i < exp_rf.size() && i < rf_q.size(); i++) begin
            chk("rf_wr_cycle", 64'(rf_q[i].cyc), 64'(exp_rf[i].cyc));
            chk("rf_wr_addr", rf_q[i].rg, exp_rf[i].rg);
            chk("rf_wr_data", rf_q[i].data, exp_rf[i].data);
        end
        chk("done_pulses", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) chk("done_cycle", 64'(done_q[0]), 64'(exp_done));
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_done - s));
        chk("rd_wr_exclusive", 64'(both_cnt), 64'd0);
    endtask

    task automatic run_vec(input int k, input int gap_pct);
        int  nl;
        bit  wb_seen;
        run_xfer(vecs[k].p, vecs[k].u, vecs[k].l, vecs[k].w, vecs[k].rn,
                 vecs[k].list, vecs[k].base, gap_pct);
        nl = $countones(vecs[k].list);
        if (nl != 0) begin
            chk("tbl_first_addr", mem_q.size() > 0 ? mem_q[0].addr : 32'hx, vecs[k].exp_lo);
            chk("tbl_last_addr", mem_q.size() > 0 ? mem_q[mem_q.size()-1].addr : 32'hx,
                vecs[k].exp_hi);
        end
        wb_seen = rf_q.size() > (vecs[k].l ? nl : 0);
        chk("tbl_wb_present", wb_seen, vecs[k].exp_wb);
        if (vecs[k].exp_wb && rf_q.size() > 0) begin
            chk("tbl_wb_reg", rf_q[rf_q.size()-1].rg, vecs[k].rn);
            chk("tbl_wb_data", rf_q[rf_q.size()-1].data, vecs[k].exp_wbv);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            p     u     l     w     rn     list      base           lo             hi             wb    wbv
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 16'h0721, 32'h0000_1000, 32'h0000_1000, 32'h0000_1010, 1'b1, 32'h0000_1014};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 16'h0721, 32'h0000_2000, 32'h0000_1FEC, 32'h0000_1FFC, 1'b1, 32'h0000_1FEC};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  16'h0721, 32'h0000_3000, 32'h0000_2FF0, 32'h0000_3000, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  16'h0003, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h0000_0004};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  16'h0000, 32'h0000_4000, 32'h0,         32'h0,         1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  16'h8001, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  16'hFFFF, 32'h0000_0100, 32'h0000_00C4, 32'h0000_0100, 1'b1, 32'h0000_00C0};

        reset_in = 1'b0; ldm_stm_start_in = 1'b0; reg_list_in = '0; base_addr_in = '0;
        rn_in = '0; p_in = 1'b0; u_in = 1'b0; l_in = 1'b0; w_in = 1'b0;
        reg_addr_in = '0; ldm_stm_en_in = 1'b0; mem_rdata_in = 32'h5555_AAAA;
        step(); step();
        chk("reset_state", outs_or(), 1'b0);
        reset_in = 1'b1;
        step();

        for (int k = 0; k < 7; k++) run_vec(k, (k % 2 == 1) ? 40 : 0);

        // Reset two beats into an LDMIA aborts the transfer immediately.
        mem_q.delete(); rf_q.delete(); done_q.delete();
        ldm_stm_start_in = 1'b1; reg_list_in = 16'h0721; base_addr_in = 32'h1000;
        rn_in = 4'd13; p_in = 1'b0; u_in = 1'b1; l_in = 1'b1; w_in = 1'b1;
        step();
        ldm_stm_start_in = 1'b0; ldm_stm_en_in = 1'b1; reg_addr_in = 4'd0;
        step();
        reg_addr_in = 4'd5;
        step();
        chk("rst_pre_beats", 64'(mem_q.size()), 64'd2);
        reset_in = 1'b0;
        #1;
        chk("rst_async_clear", outs_or(), 1'b0);
        reg_addr_in = 4'd8;
        step(); step();
        chk("rst_held_clear", outs_or(), 1'b0);
        reset_in = 1'b1;
        mem_q.delete(); rf_q.delete(); done_q.delete(); busy_cnt = 0;
        repeat (4) begin
            reg_addr_in = 4'($urandom); step();
        end
        ldm_stm_en_in = 1'b0;
        chk("idle_beats_ignored", 64'(mem_q.size() + rf_q.size() + done_q.size() + busy_cnt), 64'd0);
        run_vec(5, 20);

        // Randomized transfers.
        for (int t = 0; t < 30; t++) begin
            logic [15:0] lst;
            int          sel;
            sel = int'($urandom_range(9));
            lst = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
            run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     4'($urandom), lst, $urandom, int'($urandom_range(60)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
